mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 161 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding load/store engine between the core and
// a simple req/ack memory bus.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start               request strobe, only looked at while idle
//   is_store, op, addr  access kind, width code (op[1:0]) and byte address
//   wdata               right-justified store data
//   busy                engine is not idle
//   done                one-cycle completion pulse
//   misaligned          with done: rejected (alignment or illegal width)
//   bus_err             with done: no ack within TIMEOUT access cycles
//   rdata_aligned       last load word shifted so the addressed byte is [7:0]
//   mem_req/we/addr/be/wdata, mem_rdata, mem_ack   memory bus

// One byte lane: its byte enable and its slice of the replicated store data.
module mau_lane #(
  parameter int LANE = 0
) (
  input  logic [1:0] size,
  input  logic [1:0] off,
  input  logic [7:0] b_own,   // wdata byte that sits in this lane for a word
  input  logic [7:0] b_lo,    // wdata[7:0]
  input  logic [7:0] b_hi,    // wdata[15:8]
  output logic       be,
  output logic [7:0] data
);
  localparam logic [1:0] L = 2'(LANE);

  always_comb begin
    be   = 1'b0;
    data = b_lo;
    case (size)
      2'b00: be = (off == L);
      2'b01: begin
        // legal halves have off[0]=0, so the upper address bit picks the pair
        be   = (off[1] == L[1]);
        data = L[0] ? b_hi : b_lo;
      end
      default: begin
        be   = 1'b1;
        data = b_own;
      end
    endcase
  end
endmodule

module mem_access_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        misaligned,
  output logic        bus_err,
  output logic [31:0] rdata_aligned,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;
  localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERR} state_t;

  state_t state, state_d;
  logic [7:0] cnt;
  logic       st_r;
  logic [1:0] off_r;
  logic       berr_r;
  logic       legal;

  logic [NUM_LANES-1:0]            lane_be;
  logic [NUM_LANES-1:0][VEC_W-1:0] lane_data;

  // op[2] is the sign/zero-extend select, handled downstream
  logic unused_op2;
  assign unused_op2 = op[2];

  always_comb begin
    case (op[1:0])
      2'b00:   legal = 1'b1;
      2'b01:   legal = ~addr[0];
      2'b10:   legal = (addr[1:0] == 2'b00);
      default: legal = 1'b0;
    endcase
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    mau_lane #(.LANE(i)) u_lane (
      .size  (op[1:0]),
      .off   (addr[1:0]),
      .b_own (wdata[VEC_W*i +: VEC_W]),
      .b_lo  (wdata[7:0]),
      .b_hi  (wdata[15:8]),
      .be    (lane_be[i]),
      .data  (lane_data[i])
    );
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start) state_d = legal ? ACCESS : ERR;
      ACCESS:  if (mem_ack || cnt == TLAST) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      st_r          <= 1'b0;
      off_r         <= '0;
      berr_r        <= 1'b0;
      mem_addr      <= '0;
      mem_be        <= '0;
      mem_wdata     <= '0;
      rdata_aligned <= '0;
    end else begin
      state <= state_d;
      if (state == IDLE && start) begin
        st_r      <= is_store;
        off_r     <= addr[1:0];
        mem_addr  <= {addr[31:2], 2'b00};
        mem_be    <= lane_be;
        mem_wdata <= lane_data;
        cnt       <= '0;
        berr_r    <= 1'b0;
      end
      if (state == ACCESS) begin
        cnt <= cnt + 8'd1;
        // ack wins over a timeout landing in the same cycle
        if (mem_ack) begin
          if (!st_r) rdata_aligned <= mem_rdata >> {off_r, 3'b000};
        end else if (cnt == TLAST) begin
          berr_r <= 1'b1;
        end
      end
    end
  end

  assign busy       = (state != IDLE);
  assign done       = (state == DONE) || (state == ERR);
  assign misaligned = (state == ERR);
  assign bus_err    = (state == DONE) && berr_r;
  assign mem_req    = (state == ACCESS);
  assign mem_we     = (state == ACCESS) && st_r;
endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        start = 1'b0, is_store = 1'b0, mem_ack = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] addr = '0, wdata = '0, mem_rdata = '0;
  logic        busy, done, misaligned, bus_err, mem_req, mem_we;
  logic [31:0] rdata_aligned, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  mem_access_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store), .op(op),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done),
    .misaligned(misaligned), .bus_err(bus_err), .rdata_aligned(rdata_aligned),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        mis;
    logic        berr;
    logic [31:0] rdata;
  } resp_t;

  resp_t sb[$];
  int pass = 0, total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  // Completion monitor: every done pops one expected response.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      resp_t r;
      total++;
      assert (sb.size() != 0) pass++;
      else $error("FAIL spurious_done: got %0d queued want >0", sb.size());
      if (sb.size() != 0) begin
        r = sb.pop_front();
        chk("misaligned", 32'(misaligned), 32'(r.mis));
        chk("bus_err", 32'(bus_err), 32'(r.berr));
        chk("rdata_aligned", rdata_aligned, r.rdata);
      end
    end else begin
      chk("flags_without_done", {30'd0, misaligned, bus_err}, 32'd0);
    end
  end

  // One access: drive at cycle 0, ack at cycle ack_at (0 = never).
  task automatic run(input string tag, input logic st, input logic [2:0] o,
                     input logic [31:0] a, input logic [31:0] wd,
                     input int ack_at, input logic [31:0] rd, input logic hold,
                     input logic e_mis, input logic e_berr, input logic [31:0] e_rd,
                     input logic [31:0] e_addr, input logic [3:0] e_be,
                     input logic [31:0] e_wd, input int e_done, input int e_req);
    int got = 0, reqs = 0;
    resp_t r;
    r.mis = e_mis; r.berr = e_berr; r.rdata = e_rd;
    sb.push_back(r);
    @(negedge clk);
    start = 1'b1; is_store = st; op = o; addr = a; wdata = wd;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      // scramble inputs to prove the registered copies are used
      addr = ~a; wdata = ~wd; is_store = ~st;
      if (mem_req) reqs++;
      if (cyc == 1) begin
        chk({tag, ".busy"}, 32'(busy), 32'd1);
        if (!e_mis) begin
          chk({tag, ".mem_we"}, 32'(mem_we), 32'(st));
          chk({tag, ".mem_addr"}, mem_addr, e_addr);
          chk({tag, ".mem_be"}, 32'(mem_be), 32'(e_be));
          if (st) chk({tag, ".mem_wdata"}, mem_wdata, e_wd);
        end
      end
      if (done) begin
        got = cyc;
        start = 1'b0;
        mem_ack = 1'b0;
        break;
      end
      mem_ack   = (cyc == ack_at);
      mem_rdata = (cyc == ack_at) ? rd : 32'h5A5A_A5A5;
    end
    start = 1'b0;
    mem_ack = 1'b0;
    chk({tag, ".done_cycle"}, 32'(got), 32'(e_done));
    chk({tag, ".req_cycles"}, 32'(reqs), 32'(e_req));
    @(negedge clk);
    chk({tag, ".idle_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #3;
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.mem_req", 32'(mem_req), 32'd0);
    chk("rst.rdata", rdata_aligned, 32'd0);
    chk("rst.mem_be", 32'(mem_be), 32'd0);
    chk("rst.mem_addr", mem_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run("lw",      0, 3'b010, 32'h100, 0, 3, 32'hDEADBEEF, 0, 0, 0, 32'hDEADBEEF, 32'h100, 4'b1111, 0, 4, 3);
    run("lb",      0, 3'b000, 32'h103, 0, 2, 32'hAB123456, 0, 0, 0, 32'h000000AB, 32'h100, 4'b1000, 0, 3, 2);
    run("sh",      1, 3'b001, 32'h202, 32'h0000CAFE, 2, 32'hFFFFFFFF, 0, 0, 0, 32'h000000AB, 32'h200, 4'b1100, 32'hCAFECAFE, 3, 2);
    run("sb",      1, 3'b100, 32'h301, 32'h12345677, 1, 32'hFFFFFFFF, 0, 0, 0, 32'h000000AB, 32'h300, 4'b0010, 32'h77777777, 2, 1);
    run("lhu",     0, 3'b101, 32'h106, 0, 2, 32'h89ABCDEF, 0, 0, 0, 32'h000089AB, 32'h104, 4'b1100, 0, 3, 2);
    run("mis_w",   0, 3'b010, 32'h101, 0, 1, 32'h11111111, 0, 1, 0, 32'h000089AB, 0, 0, 0, 1, 0);
    run("mis_op",  1, 3'b011, 32'h100, 0, 1, 32'h11111111, 0, 1, 0, 32'h000089AB, 0, 0, 0, 1, 0);
    run("mis_h",   0, 3'b001, 32'h103, 0, 0, 0, 0, 1, 0, 32'h000089AB, 0, 0, 0, 1, 0);
    run("timeout", 0, 3'b010, 32'h200, 0, 0, 0, 0, 0, 1, 32'h000089AB, 32'h200, 4'b1111, 0, 5, 4);
    run("ack_tmo", 0, 3'b010, 32'h10C, 0, 4, 32'h55AA55AA, 0, 0, 0, 32'h55AA55AA, 32'h10C, 4'b1111, 0, 5, 4);
    run("hold",    0, 3'b000, 32'h001, 0, 2, 32'h0000C300, 1, 0, 0, 32'h000000C3, 32'h000, 4'b0010, 0, 3, 2);

    // reset in the middle of an access
    @(negedge clk);
    start = 1'b1; is_store = 1'b0; op = 3'b010; addr = 32'h400;
    @(negedge clk);
    start = 1'b0;
    chk("rstmid.req_before", 32'(mem_req), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid.req_async", 32'(mem_req), 32'd0);
    chk("rstmid.busy_async", 32'(busy), 32'd0);
    chk("rstmid.rdata_async", rdata_aligned, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'hCCCCCCCC;
    @(negedge clk);
    mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rstmid.busy_late", 32'(busy), 32'd0);
    chk("rstmid.rdata_late", rdata_aligned, 32'd0);

    run("post_rst", 0, 3'b100, 32'h002, 0, 3, 32'h00770000, 0, 0, 0, 32'h00000077, 32'h000, 4'b0100, 0, 4, 3);

    repeat (2) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end
endmodule
